// File: rtl/types.sv
// Shared execute-stage types: comparator opcodes and control-transfer kinds.
package types;

  // Encodings follow the RISC-V branch funct3 field; 2 and 3 are unused.
  typedef enum logic [2:0] {
    CMP_EQ  = 3'd0,
    CMP_NE  = 3'd1,
    CMP_LT  = 3'd4,
    CMP_GE  = 3'd5,
    CMP_LTU = 3'd6,
    CMP_GEU = 3'd7
  } cmp_op_t;

  typedef enum logic [1:0] {
    BR_COND = 2'd0,
    BR_JAL  = 2'd1,
    BR_JALR = 2'd2
  } br_kind_t;

endpackage

// File: rtl/cmpunit.sv
// Branch condition comparator; undefined opcodes evaluate to not-taken.
module cmpunit
  import types::*;
#(
  parameter int XLEN = 32
) (
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] b,
  input  cmp_op_t         op,
  output logic            result
);

  logic signed [XLEN-1:0] a_s;
  logic signed [XLEN-1:0] b_s;

  assign a_s = a;
  assign b_s = b;

  always_comb begin
    result = 1'b0;
    case (op)
      CMP_EQ:  result = (a == b);
      CMP_NE:  result = (a != b);
      CMP_LT:  result = (a_s < b_s);
      CMP_GE:  result = (a_s >= b_s);
      CMP_LTU: result = (a < b);
      CMP_GEU: result = (a >= b);
      default: result = 1'b0;
    endcase
  end

endmodule

// File: rtl/branch_resolve.sv
// Execute-stage branch resolution: direction, target, mispredict redirect and flush.
// Optional statistics counters are enabled by defining BRANCH_RESOLVE_STATS_EN.
module branch_resolve
  import types::*;
#(
  parameter int XLEN   = 32,
  parameter int STAT_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  br_kind_t          in_kind,
  input  cmp_op_t           in_cmp_op,
  input  logic [XLEN-1:0]   in_pc,
  input  logic [XLEN-1:0]   in_imm,
  input  logic [XLEN-1:0]   in_rs1,
  input  logic [XLEN-1:0]   in_rs2,
  input  logic              in_pred_taken,
  input  logic [XLEN-1:0]   in_pred_target,
  output logic              out_valid,
  output logic              out_taken,
  output logic [XLEN-1:0]   out_target,
  output logic [XLEN-1:0]   out_link,
  output logic              out_misaligned,
  output logic              redirect_valid,
  input  logic              redirect_ready,
  output logic [XLEN-1:0]   redirect_pc,
  output logic              flush
`ifdef BRANCH_RESOLVE_STATS_EN
  ,
  output logic [STAT_W-1:0] stat_branches,
  output logic [STAT_W-1:0] stat_mispredicts
`endif
);

  // The first REDIRECT cycle is the result cycle itself (flush high); S_REDIRECT
  // covers the cycles after it until fetch takes the redirect.
  typedef enum logic {S_IDLE, S_REDIRECT} state_t;

  state_t          state_q;
  logic            vld_p0;
  logic            have_p0;
  br_kind_t        kind_p0;
  cmp_op_t         op_p0;
  logic [XLEN-1:0] pc_p0, imm_p0, rs1_p0, rs2_p0, ptgt_p0, link_p0;
  logic            pt_p0;

  logic            accept;
  logic            cmp_taken;
  logic            taken;
  logic [XLEN-1:0] target;
  logic [XLEN-1:0] jalr_sum;
  logic [XLEN-1:0] actual_next;
  logic            misaligned;
  logic            mispredict;

  assign accept   = in_valid && in_ready;
  assign in_ready = (state_q == S_IDLE) && !flush && !rst;

  // ---- stage p0: operand capture ----
  always_ff @(posedge clk) begin
    if (accept) begin
      kind_p0 <= in_kind;
      op_p0   <= in_cmp_op;
      pc_p0   <= in_pc;
      imm_p0  <= in_imm;
      rs1_p0  <= in_rs1;
      rs2_p0  <= in_rs2;
      pt_p0   <= in_pred_taken;
      ptgt_p0 <= in_pred_target;
      link_p0 <= in_pc + XLEN'(4);
    end
  end

  cmpunit #(.XLEN(XLEN)) u_cmp (
    .a      (rs1_p0),
    .b      (rs2_p0),
    .op     (op_p0),
    .result (cmp_taken)
  );

  // ---- stage p0: resolution from the captured operands ----
  always_comb begin
    jalr_sum    = rs1_p0 + imm_p0;
    taken       = (kind_p0 == BR_COND) ? cmp_taken : 1'b1;
    target      = (kind_p0 == BR_JALR) ? {jalr_sum[XLEN-1:1], 1'b0} : (pc_p0 + imm_p0);
    actual_next = taken ? target : link_p0;
    misaligned  = taken && (target[1:0] != 2'b00);
    mispredict  = !misaligned &&
                  ((taken != pt_p0) || (taken && pt_p0 && (target != ptgt_p0)));
  end

  // have_p0 keeps the data outputs at zero until the first result after reset.
  assign out_valid      = vld_p0;
  assign out_taken      = have_p0 && taken;
  assign out_target     = have_p0 ? target : '0;
  assign out_link       = have_p0 ? link_p0 : '0;
  assign out_misaligned = have_p0 && misaligned;
  assign flush          = vld_p0 && mispredict;
  assign redirect_valid = flush || (state_q == S_REDIRECT);
  assign redirect_pc    = have_p0 ? actual_next : '0;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      vld_p0  <= 1'b0;
      have_p0 <= 1'b0;
    end else begin
      vld_p0 <= accept;
      if (accept) have_p0 <= 1'b1;
      case (state_q)
        S_IDLE:     if (flush && !redirect_ready) state_q <= S_REDIRECT;
        S_REDIRECT: if (redirect_ready) state_q <= S_IDLE;
        default:    state_q <= S_IDLE;
      endcase
    end
  end

`ifdef BRANCH_RESOLVE_STATS_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      stat_branches    <= '0;
      stat_mispredicts <= '0;
    end else begin
      if (vld_p0) stat_branches <= stat_branches + STAT_W'(1);
      if (flush)  stat_mispredicts <= stat_mispredicts + STAT_W'(1);
    end
  end
`else
  // STAT_W only sizes the counters, which are absent in this build.
  if (STAT_W < 1) begin : g_stat_w_unused
  end
`endif

endmodule
